// File: rtl/bank_core_req_queue.sv
// rtl/bank_core_req_queue.sv - per-bank core request group buffer with lane serializer
//
// Buffers up to QUEUE_SIZE multi-lane request groups. It presents the valid
// lanes of the oldest group one per cycle, lowest lane index first.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   in_valid          per-lane valid mask; a non-zero mask offers a group
//   in_addr/rw/byteen/data/tag  group fields (flat, lane 0 in the LSBs)
//   in_ready          a group can be accepted (state only)
//   out_valid         a lane is presented
//   out_tid           lane index of the presented lane
//   out_addr/rw/byteen/data/tag  presented lane fields and group tag
//   out_last          presented lane is the last remaining lane of its group
//   out_ready         bank accepts the presented lane
module bank_core_req_queue #(
  parameter int NUM_REQUESTS    = 4,
  parameter int WORD_ADDR_WIDTH = 30,
  parameter int WORD_SIZE       = 4,
  parameter int TAG_WIDTH       = 8,
  parameter int QUEUE_SIZE      = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQUESTS-1:0]                in_valid,
  input  logic [NUM_REQUESTS*WORD_ADDR_WIDTH-1:0] in_addr,
  input  logic [NUM_REQUESTS-1:0]                in_rw,
  input  logic [NUM_REQUESTS*WORD_SIZE-1:0]      in_byteen,
  input  logic [NUM_REQUESTS*WORD_SIZE*8-1:0]    in_data,
  input  logic [TAG_WIDTH-1:0]                   in_tag,
  output logic                                   in_ready,
  output logic                                   out_valid,
  output logic [((NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1)-1:0] out_tid,
  output logic [WORD_ADDR_WIDTH-1:0]             out_addr,
  output logic                                   out_rw,
  output logic [WORD_SIZE-1:0]                   out_byteen,
  output logic [WORD_SIZE*8-1:0]                 out_data,
  output logic [TAG_WIDTH-1:0]                   out_tag,
  output logic                                   out_last,
  input  logic                                   out_ready
);

  localparam int TID_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;
  localparam int PTR_W = $clog2(QUEUE_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_SIZE);

  // Group storage; contents are deliberately left unreset.
  logic [NUM_REQUESTS-1:0]                       mask_mem [QUEUE_SIZE];
  logic [NUM_REQUESTS-1:0][WORD_ADDR_WIDTH-1:0]  addr_mem [QUEUE_SIZE];
  logic [NUM_REQUESTS-1:0]                       rw_mem   [QUEUE_SIZE];
  logic [NUM_REQUESTS-1:0][WORD_SIZE-1:0]        be_mem   [QUEUE_SIZE];
  logic [NUM_REQUESTS-1:0][WORD_SIZE*8-1:0]      data_mem [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]                          tag_mem  [QUEUE_SIZE];

  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [PTR_W-1:0]        rptr_q, rptr_d;
  logic [PTR_W-1:0]        rptr_nxt;
  logic [NUM_REQUESTS-1:0] rem_q, rem_d;
  logic [NUM_REQUESTS-1:0] tid_onehot;
  logic [TID_W-1:0]        tid;
  logic                    push, fire, pop;

  assign in_ready  = reset & (count_q != FULL_CNT);
  assign push      = (|in_valid) & in_ready;
  assign out_valid = (count_q != '0);
  assign out_last  = (rem_q != '0) && ((rem_q & (rem_q - NUM_REQUESTS'(1))) == '0);
  assign fire      = out_valid & out_ready;
  assign pop       = fire & out_last;
  assign rptr_nxt  = rptr_q + PTR_W'(1);

  // Lowest set bit of the remaining-lane mask selects the presented lane.
  always_comb begin
    tid = '0;
    for (int i = NUM_REQUESTS - 1; i >= 0; i--) begin
      if (rem_q[i]) tid = TID_W'(i);
    end
  end

  assign out_tid    = tid;
  assign tid_onehot = NUM_REQUESTS'(1) << tid;

  assign out_addr   = addr_mem[rptr_q][tid];
  assign out_rw     = rw_mem[rptr_q][tid];
  assign out_byteen = be_mem[rptr_q][tid];
  assign out_data   = data_mem[rptr_q][tid];
  assign out_tag    = tag_mem[rptr_q];

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rem_d   = rem_q;

    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_nxt;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (fire) rem_d = rem_q & ~tid_onehot;

    // On pop, load the next head's mask. When only one group was held and a
    // push lands on the same edge, the new head is the group being written
    // now, so its mask is taken straight from the inputs.
    if (pop) begin
      if (count_q > CNT_W'(1)) rem_d = mask_mem[rptr_nxt];
      else if (push)           rem_d = in_valid;
      else                     rem_d = '0;
    end else if (push && (count_q == '0)) begin
      rem_d = in_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rem_q   <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem[wptr_q] <= in_valid;
      addr_mem[wptr_q] <= in_addr;
      rw_mem[wptr_q]   <= in_rw;
      be_mem[wptr_q]   <= in_byteen;
      data_mem[wptr_q] <= in_data;
      tag_mem[wptr_q]  <= in_tag;
    end
  end

endmodule

// File: tb/tb_bank_core_req_queue.sv
// tb/tb_bank_core_req_queue.sv - self-checking bench for bank_core_req_queue
module tb_bank_core_req_queue;

  logic         clk;
  logic         reset;
  logic [3:0]   in_valid;
  logic [119:0] in_addr;
  logic [3:0]   in_rw;
  logic [15:0]  in_byteen;
  logic [127:0] in_data;
  logic [7:0]   in_tag;
  logic         in_ready;
  logic         out_valid;
  logic [1:0]   out_tid;
  logic [29:0]  out_addr;
  logic         out_rw;
  logic [3:0]   out_byteen;
  logic [31:0]  out_data;
  logic [7:0]   out_tag;
  logic         out_last;
  logic         out_ready;

  bank_core_req_queue #(
    .NUM_REQUESTS(4), .WORD_ADDR_WIDTH(30), .WORD_SIZE(4), .TAG_WIDTH(8), .QUEUE_SIZE(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_rw(in_rw), .in_byteen(in_byteen),
    .in_data(in_data), .in_tag(in_tag), .in_ready(in_ready),
    .out_valid(out_valid), .out_tid(out_tid), .out_addr(out_addr), .out_rw(out_rw),
    .out_byteen(out_byteen), .out_data(out_data), .out_tag(out_tag),
    .out_last(out_last), .out_ready(out_ready)
  );

  typedef struct {
    logic [1:0]  tid;
    logic [29:0] addr;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  tag;
    logic        last;
  } lane_t;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] tag;
    logic [1:0] first_tid;
    int         lanes;
  } vec_t;

  lane_t sb[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] lane_addr(logic [7:0] tag, logic [1:0] l);
    return 30'h100 + 30'(tag) * 30'd8 + 30'(l);
  endfunction
  function automatic logic [31:0] lane_data(logic [7:0] tag, logic [1:0] l);
    return {tag, 6'd0, l, 16'hC0DE};
  endfunction
  function automatic logic lane_rw(logic [7:0] tag, logic [1:0] l);
    return tag[0] ^ l[0];
  endfunction
  function automatic logic [3:0] lane_be(logic [7:0] tag, logic [1:0] l);
    return tag[3:0] ^ {2'b00, l} ^ 4'hA;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [3:0] mask, input logic [7:0] tag);
    lane_t e;
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) begin
        e.tid  = 2'(l);
        e.addr = lane_addr(tag, 2'(l));
        e.rw   = lane_rw(tag, 2'(l));
        e.be   = lane_be(tag, 2'(l));
        e.data = lane_data(tag, 2'(l));
        e.tag  = tag;
        e.last = (4'(mask >> (l + 1)) == 4'd0);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drive_group(input logic [3:0] mask, input logic [7:0] tag);
    in_valid = mask;
    in_tag   = tag;
    for (int l = 0; l < 4; l++) begin
      in_addr[l*30 +: 30]  = lane_addr(tag, 2'(l));
      in_rw[l]             = lane_rw(tag, 2'(l));
      in_byteen[l*4 +: 4]  = lane_be(tag, 2'(l));
      in_data[l*32 +: 32]  = lane_data(tag, 2'(l));
    end
  endtask

  // Called and returns at posedge+1; the group is taken on the first edge
  // at which in_ready is high.
  task automatic push_group(input logic [3:0] mask, input logic [7:0] tag);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("push_ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      drive_group(mask, tag);
      sb_push(mask, tag);
      @(posedge clk); #1;
      in_valid = 4'b0000;
    end
  endtask

  task automatic drain;
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: every lane that fires must be the next expected lane.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_lane", 64'(out_tid), 64'hFFFF);
      end else begin
        lane_t e;
        e = sb.pop_front();
        chk("lane_tid",  64'(out_tid),    64'(e.tid));
        chk("lane_addr", 64'(out_addr),   64'(e.addr));
        chk("lane_rw",   64'(out_rw),     64'(e.rw));
        chk("lane_be",   64'(out_byteen), 64'(e.be));
        chk("lane_data", 64'(out_data),   64'(e.data));
        chk("lane_tag",  64'(out_tag),    64'(e.tag));
        chk("lane_last", 64'(out_last),   64'(e.last));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{mask: 4'b0001, tag: 8'h00, first_tid: 2'd0, lanes: 1};
    vecs[1] = '{mask: 4'b1011, tag: 8'h5A, first_tid: 2'd0, lanes: 3};
    vecs[2] = '{mask: 4'b1111, tag: 8'h11, first_tid: 2'd0, lanes: 4};
    vecs[3] = '{mask: 4'b1000, tag: 8'h22, first_tid: 2'd3, lanes: 1};
    vecs[4] = '{mask: 4'b0110, tag: 8'h23, first_tid: 2'd1, lanes: 2};

    reset     = 1'b0;
    out_ready = 1'b0;
    drive_group(4'b0000, 8'h00);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_out_tid",   64'(out_tid),   64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready",  64'(in_ready),  64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Table-driven groups with no backpressure
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      push_group(vecs[i].mask, vecs[i].tag);
      @(negedge clk);
      chk("vec_first_valid", 64'(out_valid), 64'd1);
      chk("vec_first_tid",   64'(out_tid),   64'(vecs[i].first_tid));
      n = 0;
      while (out_valid && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("vec_lane_cycles", 64'(n), 64'(vecs[i].lanes));
      chk("vec_idle_ready",  64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end

    // Fill to capacity with the bank stalled
    out_ready = 1'b0;
    push_group(4'b0001, 8'h40);
    push_group(4'b0011, 8'h41);
    push_group(4'b1100, 8'h42);
    push_group(4'b1111, 8'h43);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    drive_group(4'b0101, 8'h44);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_hold_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_before_pop", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_after_pop", 64'(in_ready), 64'd1);
    drain();

    // Stall stability
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_group(4'b0110, 8'h33);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_tid",   64'(out_tid),   64'd1);
      chk("stall_addr",  64'(out_addr),  64'(lane_addr(8'h33, 2'd1)));
      chk("stall_data",  64'(out_data),  64'(lane_data(8'h33, 2'd1)));
      chk("stall_last",  64'(out_last),  64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Wrap-around with random backpressure
    fork
      begin
        for (int g = 0; g < 9; g++) push_group(4'b0001 << (g % 4), 8'h80 + 8'(g));
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-group with two groups queued
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_group(4'b1011, 8'h61);
    push_group(4'b0011, 8'h62);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'd0);
    chk("mid_rst_last",  64'(out_last),  64'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_ready", 64'(in_ready),  64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_group(4'b0100, 8'h70);
    @(negedge clk);
    chk("post_rst_first_valid", 64'(out_valid), 64'd1);
    chk("post_rst_first_tid",   64'(out_tid),   64'd2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
